rf_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback requesters: ALU (port A) and load/store unit (port L).
- Arbitration is round-robin, with one registered output stage that drives the register file's reg_write, write_reg_num1 and write_data inputs.
- Keeps a pending-write scoreboard per architectural register and raises a stall when an issuing instruction reads a register with an outstanding write.

---
 rtl/rf_wb_arbiter.sv | 97 +++++++++
 tb/tb_rf_wb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and the LSU,
// with a per-register pending-write scoreboard that raises RAW/WAW stalls at issue.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_rd,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 l_valid,
  input  logic [ADDR_W-1:0]    l_rd,
  input  logic [DATA_W-1:0]    l_data,
  output logic                 l_ready,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [ADDR_W-1:0]    issue_rs1,
  input  logic [ADDR_W-1:0]    issue_rs2,
  output logic                 stall,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    write_reg_num1,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {PORT_A = 1'b0, PORT_L = 1'b1} port_e;

  port_e             last_grant;
  logic              grant_a, grant_l, both_vld;
  logic              vld_p0;
  logic [ADDR_W-1:0] rd_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic [DATA_W-1:0] data_p1;
  logic [NREG-1:0]   pending_nxt;
  logic              issue_set;

  // Stage p0: combinational grant and selection of the accepted request
  always_comb begin
    both_vld = a_valid & l_valid;
    grant_a  = a_valid & (~l_valid | (last_grant == PORT_L));
    grant_l  = l_valid & ~grant_a;
    a_ready  = grant_a & ~rst;
    l_ready  = grant_l & ~rst;
    vld_p0   = a_ready | l_ready;
    rd_p0    = a_ready ? a_rd : l_rd;
    data_p0  = a_ready ? a_data : l_data;
  end

  always_comb begin
    stall = ~rst & issue_valid &
            (((issue_rs1 != '0) & pending[issue_rs1]) |
             ((issue_rs2 != '0) & pending[issue_rs2]) |
             ((issue_rd  != '0) & pending[issue_rd]));
    issue_set = issue_valid & ~stall & (issue_rd != '0);
  end

  // Clear is applied before set so a same-edge issue to the retiring register keeps it pending
  always_comb begin
    pending_nxt = pending;
    if (vld_p1)
      pending_nxt[rd_p1] = 1'b0;
    if (issue_set)
      pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Stage p1: registered write port toward the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_p1      <= '0;
      data_p1    <= '0;
      last_grant <= PORT_L;
      pending    <= '0;
    end else begin
      vld_p1 <= vld_p0 & (rd_p0 != '0);
      if (vld_p0) begin
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
      end
      if (both_vld)
        last_grant <= grant_a ? PORT_A : PORT_L;
      pending <= pending_nxt;
    end
  end

  assign reg_write      = vld_p1;
  assign write_reg_num1 = rd_p1;
  assign write_data     = data_p1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, write latency, scoreboard and reset.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk, rst;
  logic              a_valid, l_valid, a_ready, l_ready;
  logic [ADDR_W-1:0] a_rd, l_rd;
  logic [DATA_W-1:0] a_data, l_data;
  logic              issue_valid, stall, reg_write;
  logic [ADDR_W-1:0] issue_rd, issue_rs1, issue_rs2, write_reg_num1;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       pending;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .stall(stall),
    .reg_write(reg_write), .write_reg_num1(write_reg_num1),
    .write_data(write_data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst = 1;
    a_valid = 0; a_rd = 0; a_data = 0;
    l_valid = 0; l_rd = 0; l_data = 0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    tick(); tick();

    // reset state and ready suppression while rst is high
    chk("rst_we", reg_write, 0);
    chk("rst_num", write_reg_num1, 0);
    chk("rst_data", write_data, 0);
    chk("rst_pend", pending, 0);
    a_valid = 1; l_valid = 1; issue_valid = 1; #1;
    chk("rst_ardy", a_ready, 0);
    chk("rst_lrdy", l_ready, 0);
    rst = 0; a_valid = 0; l_valid = 0; issue_valid = 0;

    // single ALU write, one-cycle latency, one-cycle pulse, data hold
    a_valid = 1; a_rd = 5; a_data = 'h11; #1;
    chk("t1_ardy", a_ready, 1);
    chk("t1_lrdy", l_ready, 0);
    tick(); a_valid = 0;
    chk("t1_we", reg_write, 1);
    chk("t1_num", write_reg_num1, 5);
    chk("t1_data", write_data, 'h11);
    tick();
    chk("t1_we_off", reg_write, 0);
    chk("t1_num_hold", write_reg_num1, 5);
    chk("t1_data_hold", write_data, 'h11);

    // continuous tie alternates A,L,A,L with no idle cycle
    a_valid = 1; a_rd = 1; a_data = 'hA;
    l_valid = 1; l_rd = 2; l_data = 'hB; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_ardy", a_ready, (i % 2 == 0));
      chk("t2_lrdy", l_ready, (i % 2 == 1));
      tick();
      chk("t2_we", reg_write, 1);
      chk("t2_num", write_reg_num1, (i % 2 == 0) ? 1 : 2);
      chk("t2_data", write_data, (i % 2 == 0) ? 'hA : 'hB);
    end
    a_valid = 0; l_valid = 0;
    tick();
    chk("t2_we_off", reg_write, 0);

    // x0 writeback is accepted and dropped
    l_valid = 1; l_rd = 0; l_data = 'hFF; #1;
    chk("t3_lrdy", l_ready, 1);
    tick(); l_valid = 0;
    chk("t3_we", reg_write, 0);
    chk("t3_pend", pending, 0);

    // RAW on rs1: stall holds through the reg_write cycle
    issue_valid = 1; issue_rd = 7; #1;
    chk("t4_nostall", stall, 0);
    tick();
    chk("t4_pend7", pending, 32'h80);
    issue_rd = 0; issue_rs1 = 7;
    a_valid = 1; a_rd = 7; a_data = 'h77; #1;
    chk("t4_stall_rs1", stall, 1);
    chk("t4_ardy", a_ready, 1);
    tick(); a_valid = 0;
    chk("t4_we", reg_write, 1);
    chk("t4_num", write_reg_num1, 7);
    chk("t4_stall_wb", stall, 1);
    tick();
    chk("t4_pend_clr", pending, 0);
    chk("t4_stall_off", stall, 0);

    // rs2 and rd hazard terms; stalled issue must not set its rd
    issue_rs1 = 0; issue_rd = 9; #1;
    tick();
    chk("t4_pend9", pending, 32'h200);
    issue_rd = 0; issue_rs2 = 9; #1;
    chk("t4_stall_rs2", stall, 1);
    issue_rs2 = 0; issue_rd = 9; #1;
    chk("t4_stall_rd", stall, 1);
    issue_rd = 10; issue_rs1 = 9; #1;
    chk("t4_stall_mix", stall, 1);
    tick();
    chk("t4_no_set", pending, 32'h200);
    issue_valid = 0; #1;
    chk("t4_noissue", stall, 0);
    issue_rd = 0; issue_rs1 = 0;
    l_valid = 1; l_rd = 9; l_data = 'h99; #1;
    chk("t4_lrdy", l_ready, 1);
    tick(); l_valid = 0;
    chk("t4_we9", reg_write, 1);
    chk("t4_data9", write_data, 'h99);
    tick();
    chk("t4_pend_clr9", pending, 0);

    // clear and set of x3 on the same edge: set wins
    a_valid = 1; a_rd = 3; a_data = 'h33; #1;
    tick(); a_valid = 0;
    chk("t5_we", reg_write, 1);
    chk("t5_num", write_reg_num1, 3);
    issue_valid = 1; issue_rd = 3; #1;
    chk("t5_nostall", stall, 0);
    tick(); issue_valid = 0;
    chk("t5_pend3", pending, 32'h8);

    // build pending=0xF0 with reg_write=1, pointer left on A, then reset
    a_valid = 1; a_rd = 3; a_data = 'h3;
    issue_valid = 1; issue_rd = 4; #1;
    tick(); a_valid = 0; issue_rd = 5; #1;
    tick(); issue_rd = 6; #1;
    tick(); issue_rd = 7;
    a_valid = 1; a_rd = 1; a_data = 'h1;
    l_valid = 1; l_rd = 2; l_data = 'h2; #1;
    chk("t6_ardy", a_ready, 1);
    tick();
    a_valid = 0; l_valid = 0; issue_valid = 0; issue_rd = 0;
    chk("t6_pend", pending, 32'hF0);
    chk("t6_we", reg_write, 1);
    rst = 1; issue_valid = 1; issue_rs1 = 4; #1;
    chk("t6_rst_stall", stall, 0);
    a_valid = 1; l_valid = 1; #1;
    chk("t6_rst_ardy", a_ready, 0);
    chk("t6_rst_lrdy", l_ready, 0);
    tick();
    chk("t6_we_off", reg_write, 0);
    chk("t6_pend_off", pending, 0);
    rst = 0; #1;
    chk("t6_stall_post", stall, 0);
    chk("t6_tie_a", a_ready, 1);
    chk("t6_tie_l", l_ready, 0);
    issue_valid = 0;
    tick(); a_valid = 0; l_valid = 0;
    chk("t6_we_post", reg_write, 1);
    chk("t6_num_post", write_reg_num1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
